bmp_frame_capture: RTL and testbench

- Parametrised successor to the pixel-pair BMP writer. Captures one frame of RGB888 pixels (PPC pixels per beat) from the image pipeline into on-chip frame memory.
- Then replays the frame as a valid/ready byte stream in Windows 24-bit BMP order: 54-byte header computed from the parameters, rows bottom-up, BGR byte order, each row zero-padded to a 4-byte boundary.
- Sits at the pipeline tail. Feeds a UART/DMA sink or a simulation byte dumper, replacing the fixed-size behavioural file writer with synthesizable RTL.

---
 rtl/bmp_frame_capture.sv | 256 +++++++++++++++++++++++++
 tb/tb_bmp_frame_capture.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmp_frame_capture.sv
// Captures one RGB888 frame (PPC pixels per beat) into on-chip memory. It then
// replays the frame as a 24-bit Windows BMP byte stream on a valid/ready port.
//
// Ports:
//   HCLK, HRESETn             clock, async active-low reset
//   in_valid/in_ready/in_data pixel beat input, pixel p at [24p+23:24p] = {R,G,B}
//   frame_done                one-cycle pulse after the last beat of a frame
//   out_valid/out_ready       byte stream handshake
//   out_data/out_last         stream byte, high with the final byte of the file
//   frame_count               number of files fully emitted (wraps)
module bmp_frame_capture #(
    parameter int unsigned WIDTH     = 768,
    parameter int unsigned HEIGHT    = 512,
    parameter int unsigned PPC       = 2,
    parameter int unsigned HEADER_EN = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [24*PPC-1:0]     in_data,
    output logic                  frame_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic                  out_last,
    output logic [15:0]           frame_count
);

    localparam int unsigned COLS = WIDTH / PPC;
    localparam int unsigned NPIX = WIDTH * HEIGHT;
    localparam int unsigned ROWB = ((WIDTH * 3 + 3) / 4) * 4;
    localparam int unsigned PAD  = ROWB - WIDTH * 3;
    localparam int unsigned IMG  = ROWB * HEIGHT;
    localparam int unsigned FSZ  = 54 + IMG;

    localparam int unsigned CW = (COLS > 1)   ? $clog2(COLS)   : 1;
    localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned XW = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
    localparam int unsigned AW = (NPIX > 1)   ? $clog2(NPIX)   : 1;
    localparam int unsigned PW = 2;

    // Header image, byte 0 in the least significant byte; fields little-endian.
    localparam logic [431:0] HDR = {128'd0, 32'(IMG), 32'd0, 16'd24, 16'd1,
                                    32'(HEIGHT), 32'(WIDTH), 32'd40, 32'd54,
                                    32'd0, 32'(FSZ), 8'h4D, 8'h42};

    localparam logic [2:0] S_CAPTURE = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_READ    = 3'd2;
    localparam logic [2:0] S_PIX     = 3'd3;
    localparam logic [2:0] S_PAD     = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          frame_done_q, frame_done_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [XW-1:0] x_q, x_d;
    logic [1:0]    k_q, k_d;
    logic [PW-1:0] pad_q, pad_d;
    logic [5:0]    hdr_q, hdr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;

    logic [23:0]   mem [NPIX];
    logic [23:0]   rd_pix_q;
    logic          accept_c;
    logic          load_ok_c;
    logic [AW-1:0] wr_base_c;

    assign accept_c  = (state_q == S_CAPTURE) && in_valid;
    // Output register may take a new byte when empty or being drained this cycle.
    assign load_ok_c = !out_valid_q || out_ready;
    // Row 0 of the input lands in the top memory row so readout is bottom-up.
    assign wr_base_c = AW'((AW'(HEIGHT - 1) - AW'(row_q)) * AW'(WIDTH))
                     + AW'(AW'(col_q) * AW'(PPC));

    // Frame memory: PPC writes per accepted beat, one registered read per pixel.
    always_ff @(posedge HCLK) begin
        if (accept_c) begin
            for (int p = 0; p < int'(PPC); p++) begin
                mem[wr_base_c + AW'(p)] <= in_data[24*p +: 24];
            end
        end
        if (state_q == S_READ) begin
            rd_pix_q <= mem[rd_addr_q];
        end
    end

    // State and counter registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= S_CAPTURE;
            in_ready_q    <= 1'b1;
            frame_done_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 8'd0;
            out_last_q    <= 1'b0;
            frame_count_q <= 16'd0;
            col_q         <= '0;
            row_q         <= '0;
            x_q           <= '0;
            k_q           <= '0;
            pad_q         <= '0;
            hdr_q         <= '0;
            rd_addr_q     <= '0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            frame_done_q  <= frame_done_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            frame_count_q <= frame_count_d;
            col_q         <= col_d;
            row_q         <= row_d;
            x_q           <= x_d;
            k_q           <= k_d;
            pad_q         <= pad_d;
            hdr_q         <= hdr_d;
            rd_addr_q     <= rd_addr_d;
        end
    end

    // Next-state, counter and output-byte logic.
    always_comb begin
        state_d       = state_q;
        frame_done_d  = 1'b0;
        out_valid_d   = out_valid_q && !out_ready;
        out_data_d    = out_data_q;
        out_last_d    = out_valid_d ? out_last_q : 1'b0;
        frame_count_d = frame_count_q;
        col_d         = col_q;
        row_d         = row_q;
        x_d           = x_q;
        k_d           = k_q;
        pad_d         = pad_q;
        hdr_d         = hdr_q;
        rd_addr_d     = rd_addr_q;

        case (state_q)
            S_CAPTURE: begin
                if (accept_c) begin
                    if (col_q == CW'(COLS - 1)) begin
                        col_d = '0;
                        if (row_q == RW'(HEIGHT - 1)) begin
                            row_d        = '0;
                            frame_done_d = 1'b1;
                            state_d      = (HEADER_EN != 0) ? S_HEADER : S_READ;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_HEADER: begin
                if (load_ok_c) begin
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    out_data_d  = HDR[{hdr_q, 3'b000} +: 8];
                    if (hdr_q == 6'd53) begin
                        hdr_d   = '0;
                        state_d = S_READ;
                    end else begin
                        hdr_d = hdr_q + 6'd1;
                    end
                end
            end
            S_READ: begin
                state_d = S_PIX;
            end
            S_PIX: begin
                // k selects B, G, R of the fetched pixel in turn.
                if (load_ok_c) begin
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    out_data_d  = rd_pix_q[{k_q, 3'b000} +: 8];
                    if (k_q == 2'd2) begin
                        k_d       = '0;
                        rd_addr_d = rd_addr_q + AW'(1);
                        if (x_q == XW'(WIDTH - 1)) begin
                            x_d = '0;
                            if (PAD != 0) begin
                                state_d = S_PAD;
                            end else if (row_q == RW'(HEIGHT - 1)) begin
                                out_last_d = 1'b1;
                                state_d    = S_DRAIN;
                            end else begin
                                row_d   = row_q + RW'(1);
                                state_d = S_READ;
                            end
                        end else begin
                            x_d     = x_q + XW'(1);
                            state_d = S_READ;
                        end
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            S_PAD: begin
                if (load_ok_c) begin
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    out_data_d  = 8'd0;
                    if (pad_q == PW'(PAD - 1)) begin
                        pad_d = '0;
                        if (row_q == RW'(HEIGHT - 1)) begin
                            out_last_d = 1'b1;
                            state_d    = S_DRAIN;
                        end else begin
                            row_d   = row_q + RW'(1);
                            state_d = S_READ;
                        end
                    end else begin
                        pad_d = pad_q + PW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Wait for the final byte to leave before re-arming capture.
                if (out_valid_q && out_ready) begin
                    state_d       = S_CAPTURE;
                    frame_count_d = frame_count_q + 16'd1;
                    col_d         = '0;
                    row_d         = '0;
                    x_d           = '0;
                    k_d           = '0;
                    pad_d         = '0;
                    hdr_d         = '0;
                    rd_addr_d     = '0;
                end
            end
            default: begin
                state_d = S_CAPTURE;
            end
        endcase

        in_ready_d = (state_d == S_CAPTURE);
    end

    assign in_ready    = in_ready_q;
    assign frame_done  = frame_done_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_bmp_frame_capture.sv
// Bench for bmp_frame_capture: three small configurations share stimulus;
// a scoreboard queue holds the expected BMP byte stream of each frame.
module tb_bmp_frame_capture;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [1:0]  sel;
    logic        in_valid;
    logic [47:0] in_data;
    logic        out_ready;

    logic [2:0]  ir, fd, ov, ol;
    logic [7:0]  od [3];
    logic [15:0] fc [3];

    logic        ir_m, fd_m, ov_m, ol_m;
    logic [7:0]  od_m;
    logic [15:0] fc_m;

    logic [7:0]  sbq [$];
    logic [7:0]  rx [0:255];
    int          nrx;
    int          errors = 0;
    int          checks = 0;

    always #5 HCLK = ~HCLK;

    assign ir_m = ir[sel];
    assign fd_m = fd[sel];
    assign ov_m = ov[sel];
    assign ol_m = ol[sel];
    assign od_m = od[sel];
    assign fc_m = fc[sel];

    bmp_frame_capture #(.WIDTH(4), .HEIGHT(2), .PPC(2), .HEADER_EN(1)) u_a (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .in_valid(in_valid && sel == 2'd0), .in_ready(ir[0]), .in_data(in_data),
        .frame_done(fd[0]), .out_valid(ov[0]), .out_ready(out_ready && sel == 2'd0),
        .out_data(od[0]), .out_last(ol[0]), .frame_count(fc[0]));

    bmp_frame_capture #(.WIDTH(3), .HEIGHT(2), .PPC(1), .HEADER_EN(1)) u_b (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .in_valid(in_valid && sel == 2'd1), .in_ready(ir[1]), .in_data(in_data[23:0]),
        .frame_done(fd[1]), .out_valid(ov[1]), .out_ready(out_ready && sel == 2'd1),
        .out_data(od[1]), .out_last(ol[1]), .frame_count(fc[1]));

    bmp_frame_capture #(.WIDTH(4), .HEIGHT(2), .PPC(2), .HEADER_EN(0)) u_c (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .in_valid(in_valid && sel == 2'd2), .in_ready(ir[2]), .in_data(in_data),
        .frame_done(fd[2]), .out_valid(ov[2]), .out_ready(out_ready && sel == 2'd2),
        .out_data(od[2]), .out_last(ol[2]), .frame_count(fc[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pixval(input int n, input int seed);
        return {8'(n + seed), 8'(16 + n + seed), 8'(32 + n + seed)};
    endfunction

    // Reference BMP file for a frame filled with pixval(raster index, seed).
    task automatic push_expected(input int w, input int h, input bit hdr, input int seed);
        int rowb = ((w * 3 + 3) / 4) * 4;
        int pad  = rowb - w * 3;
        int img  = rowb * h;
        logic [7:0]  hb [54];
        logic [23:0] pv;
        for (int i = 0; i < 54; i++) hb[i] = 8'h00;
        hb[0] = 8'h42;
        hb[1] = 8'h4D;
        for (int i = 0; i < 4; i++) begin
            hb[2 + i]  = 8'((54 + img) >> (8 * i));
            hb[10 + i] = 8'(54 >> (8 * i));
            hb[14 + i] = 8'(40 >> (8 * i));
            hb[18 + i] = 8'(w >> (8 * i));
            hb[22 + i] = 8'(h >> (8 * i));
            hb[34 + i] = 8'(img >> (8 * i));
        end
        hb[26] = 8'd1;
        hb[28] = 8'd24;
        if (hdr) for (int i = 0; i < 54; i++) sbq.push_back(hb[i]);
        for (int r = h - 1; r >= 0; r--) begin
            for (int x = 0; x < w; x++) begin
                pv = pixval(r * w + x, seed);
                sbq.push_back(pv[7:0]);
                sbq.push_back(pv[15:8]);
                sbq.push_back(pv[23:16]);
            end
            for (int i = 0; i < pad; i++) sbq.push_back(8'h00);
        end
    endtask

    // Feed one frame; called at a negative edge.
    task automatic drive_frame(input int w, input int h, input int ppc, input int seed);
        int nb = w * h / ppc;
        int cyc;
        for (int b = 0; b < nb; b++) begin
            for (int p = 0; p < ppc; p++) in_data[24*p +: 24] = pixval(b * ppc + p, seed);
            in_valid = 1'b1;
            cyc = 0;
            while (ir_m !== 1'b1) begin
                @(negedge HCLK);
                cyc++;
                if (cyc > 5000) begin
                    checks++; errors++;
                    $error("FAIL in_ready_timeout: observed no in_ready expected in_ready within 5000 cycles");
                    in_valid = 1'b0;
                    return;
                end
            end
            @(posedge HCLK);
            @(negedge HCLK);
            if (b == nb - 1) begin
                chk("frame_done_pulse", 32'(fd_m), 32'd1);
                chk("in_ready_low_after_frame", 32'(ir_m), 32'd0);
            end else if (b == 0) begin
                chk("frame_done_early", 32'(fd_m), 32'd0);
            end
        end
        in_valid = 1'b0;
        @(negedge HCLK);
        chk("frame_done_one_cycle", 32'(fd_m), 32'd0);
    endtask

    // Drain the byte stream against the scoreboard; stop_after=0 means full file.
    task automatic collect(input int stop_after, input bit rnd);
        int       got = 0;
        int       cyc = 0;
        bit       stalled = 1'b0;
        bit       rdy;
        logic [7:0] pd = 8'h00;
        logic     pl = 1'b0;
        logic [7:0] exp;
        nrx = 0;
        forever begin
            @(negedge HCLK);
            cyc++;
            if (cyc > 20000) begin
                checks++; errors++;
                $error("FAIL stream_timeout: observed %0d bytes expected %0d more", got, sbq.size());
                break;
            end
            if (stalled) begin
                chk("stall_valid", 32'(ov_m), 32'd1);
                chk("stall_data", 32'(od_m), 32'(pd));
                chk("stall_last", 32'(ol_m), 32'(pl));
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            if (ov_m === 1'b1 && rdy) begin
                stalled = 1'b0;
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL extra_byte: observed %0h expected no byte", od_m);
                    break;
                end
                exp = sbq.pop_front();
                chk("byte", 32'(od_m), 32'(exp));
                chk("out_last", 32'(ol_m), 32'(sbq.size() == 0));
                if (nrx < 256) rx[nrx] = od_m;
                nrx++;
                got++;
                if (sbq.size() == 0 || got == stop_after) break;
            end else begin
                stalled = (ov_m === 1'b1);
                pd = od_m;
                pl = ol_m;
            end
        end
        @(posedge HCLK);
        #1 out_ready = 1'b0;
        if (stop_after == 0) begin
            @(negedge HCLK);
            chk("out_valid_after_last", 32'(ov_m), 32'd0);
            chk("in_ready_after_last", 32'(ir_m), 32'd1);
        end
    endtask

    initial begin
        HRESETn   = 1'b0;
        sel       = 2'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge HCLK);
        chk("rst_in_ready", 32'(ir_m), 32'd1);
        chk("rst_out_valid", 32'(ov_m), 32'd0);
        chk("rst_out_data", 32'(od_m), 32'd0);
        chk("rst_out_last", 32'(ol_m), 32'd0);
        chk("rst_frame_done", 32'(fd_m), 32'd0);
        chk("rst_frame_count", 32'(fc_m), 32'd0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // 4x2, PPC=2, header; next frame's first beat held on the input meanwhile
        push_expected(4, 2, 1'b1, 0);
        drive_frame(4, 2, 2, 0);
        in_data[23:0]  = pixval(0, 5);
        in_data[47:24] = pixval(1, 5);
        in_valid = 1'b1;
        collect(0, 1'b0);
        chk("a_nbytes", 32'(nrx), 32'd78);
        chk("a_fsz_b2", 32'(rx[2]), 32'h4E);
        chk("a_fsz_b3", 32'(rx[3]), 32'h00);
        chk("a_img_b34", 32'(rx[34]), 32'h18);
        chk("a_first_pix_b54", 32'(rx[54]), 32'h24);
        chk("a_frame_count1", 32'(fc_m), 32'd1);

        // Second frame, random sink stalls
        push_expected(4, 2, 1'b1, 5);
        drive_frame(4, 2, 2, 5);
        collect(0, 1'b1);
        chk("a_frame_count2", 32'(fc_m), 32'd2);

        // Reset in the middle of the stream, then a fresh frame
        push_expected(4, 2, 1'b1, 9);
        drive_frame(4, 2, 2, 9);
        collect(40, 1'b0);
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(ov_m), 32'd0);
        chk("midrst_in_ready", 32'(ir_m), 32'd1);
        chk("midrst_frame_count", 32'(fc_m), 32'd0);
        sbq.delete();
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        push_expected(4, 2, 1'b1, 20);
        drive_frame(4, 2, 2, 20);
        collect(0, 1'b1);
        chk("postrst_nbytes", 32'(nrx), 32'd78);
        chk("postrst_frame_count", 32'(fc_m), 32'd1);

        // 3x2, PPC=1: three pad bytes per row
        sel = 2'd1;
        @(negedge HCLK);
        push_expected(3, 2, 1'b1, 0);
        drive_frame(3, 2, 1, 0);
        collect(0, 1'b0);
        chk("b_nbytes", 32'(nrx), 32'd78);
        chk("b_width_b18", 32'(rx[18]), 32'h03);
        for (int i = 63; i <= 65; i++) chk("b_pad_row0", 32'(rx[i]), 32'h00);
        for (int i = 75; i <= 77; i++) chk("b_pad_row1", 32'(rx[i]), 32'h00);
        chk("b_frame_count", 32'(fc_m), 32'd1);

        // 4x2 without header
        sel = 2'd2;
        @(negedge HCLK);
        push_expected(4, 2, 1'b0, 0);
        drive_frame(4, 2, 2, 0);
        collect(0, 1'b1);
        chk("c_nbytes", 32'(nrx), 32'd24);
        chk("c_first_byte", 32'(rx[0]), 32'h24);
        chk("c_frame_count", 32'(fc_m), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
